// File: rtl/operand_fetch_stage.sv
// Register file, busy scoreboard and operand issue register
// feeding the 3-bit-func ALU through a valid/ready handshake.
module operand_fetch_stage #(
  parameter int n    = 16,
  parameter int REGS = 8,
  parameter int AW   = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          issue_valid,
  output logic          issue_ready,
  input  logic [AW-1:0] sel_i,
  input  logic [AW-1:0] sel_j,
  input  logic [2:0]    func_in,
  input  logic [AW-1:0] dst,
  input  logic          dst_en,
  output logic [n-1:0]  ri,
  output logic [n-1:0]  rj,
  output logic [2:0]    func,
  output logic          op_valid,
  input  logic          op_ready,
  input  logic          wb_valid,
  input  logic [AW-1:0] wb_addr,
  input  logic [n-1:0]  wb_data,
  output logic          illegal
);

  logic [n-1:0]   rf_q [REGS];
  logic [REGS-1:0] busy_q, busy_d;
  logic [n-1:0]   ri_q, ri_d;
  logic [n-1:0]   rj_q, rj_d;
  logic [2:0]     func_q, func_d;
  logic           op_valid_q, op_valid_d;
  logic           illegal_q, illegal_d;

  logic           wb_we;
  logic           fwd_i, fwd_j;
  logic           stall_i, stall_j;
  logic [n-1:0]   rd_i, rd_j;
  logic           free;
  logic           accept;
  logic           legal;
  logic           acc_ok, acc_bad;

  assign wb_we = wb_valid && (wb_addr != '0);
  assign fwd_i = wb_we && (wb_addr == sel_i);
  assign fwd_j = wb_we && (wb_addr == sel_j);

  // Source read with R0 tie-off and same-cycle write-back bypass
  always_comb begin
    rd_i = '0;
    rd_j = '0;
    if (sel_i != '0) rd_i = fwd_i ? wb_data : rf_q[sel_i];
    if (sel_j != '0) rd_j = fwd_j ? wb_data : rf_q[sel_j];
  end

  // A forwarded source is never a hazard; busy[0] is never set
  assign stall_i = busy_q[sel_i] && !fwd_i;
  assign stall_j = busy_q[sel_j] && !fwd_j;

  assign free        = !op_valid_q || op_ready;
  assign issue_ready = free && !stall_i && !stall_j;
  assign accept      = issue_valid && issue_ready;
  assign legal       = func_in <= 3'd5;
  assign acc_ok      = accept && legal;
  assign acc_bad     = accept && !legal;

  // Scoreboard next state: a new writer's set beats a write-back clear
  always_comb begin
    busy_d = busy_q;
    if (wb_we) busy_d[wb_addr] = 1'b0;
    if (acc_ok && dst_en && (dst != '0)) busy_d[dst] = 1'b1;
  end

  // Operand register next state: load, drop illegal, drain or hold
  always_comb begin
    ri_d       = ri_q;
    rj_d       = rj_q;
    func_d     = func_q;
    op_valid_d = op_valid_q;
    illegal_d  = acc_bad;
    unique case (1'b1)
      acc_ok: begin
        ri_d       = rd_i;
        rj_d       = rd_j;
        func_d     = func_in;
        op_valid_d = 1'b1;
      end
      acc_bad: op_valid_d = 1'b0;
      default: if (op_ready) op_valid_d = 1'b0;
    endcase
  end

  // Register file write port
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < REGS; k++) rf_q[k] <= '0;
    end else if (wb_we) begin
      rf_q[wb_addr] <= wb_data;
    end
  end

  // Busy scoreboard
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) busy_q <= '0;
    else      busy_q <= busy_d;
  end

  // Issue register towards the ALU
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ri_q       <= '0;
      rj_q       <= '0;
      func_q     <= 3'b000;
      op_valid_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      ri_q       <= ri_d;
      rj_q       <= rj_d;
      func_q     <= func_d;
      op_valid_q <= op_valid_d;
      illegal_q  <= illegal_d;
    end
  end

  assign ri       = ri_q;
  assign rj       = rj_q;
  assign func     = func_q;
  assign op_valid = op_valid_q;
  assign illegal  = illegal_q;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Bench for operand_fetch_stage: directed table, reset corner,
// then random traffic against a register/scoreboard model.
module tb_operand_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid;
  logic        issue_ready;
  logic [2:0]  sel_i, sel_j, func_in, dst;
  logic        dst_en;
  logic [15:0] ri, rj;
  logic [2:0]  func;
  logic        op_valid;
  logic        op_ready;
  logic        wb_valid;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data;
  logic        illegal;

  int checks = 0;
  int errors = 0;

  operand_fetch_stage #(.n(16), .REGS(8), .AW(3)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .sel_i(sel_i), .sel_j(sel_j), .func_in(func_in),
    .dst(dst), .dst_en(dst_en),
    .ri(ri), .rj(rj), .func(func),
    .op_valid(op_valid), .op_ready(op_ready),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [2:0]  si, sj, fn, ds;
    logic        de, ordy, wv;
    logic [2:0]  wa;
    logic [15:0] wd;
    logic        eir, eov;
    logic [15:0] eri, erj;
    logic [2:0]  ef;
    logic        eill, cops;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(
    logic iv, logic [2:0] si, logic [2:0] sj, logic [2:0] fn,
    logic [2:0] ds, logic de, logic ordy, logic wv,
    logic [2:0] wa, logic [15:0] wd, logic eir, logic eov,
    logic [15:0] eri, logic [15:0] erj, logic [2:0] ef,
    logic eill, logic cops);
    vec_t v;
    v.iv = iv; v.si = si; v.sj = sj; v.fn = fn; v.ds = ds;
    v.de = de; v.ordy = ordy; v.wv = wv; v.wa = wa; v.wd = wd;
    v.eir = eir; v.eov = eov; v.eri = eri; v.erj = erj;
    v.ef = ef; v.eill = eill; v.cops = cops;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    issue_valid = v.iv; sel_i = v.si; sel_j = v.sj;
    func_in = v.fn; dst = v.ds; dst_en = v.de;
    op_ready = v.ordy; wb_valid = v.wv;
    wb_addr = v.wa; wb_data = v.wd;
  endtask

  task automatic idle();
    issue_valid = 0; sel_i = 0; sel_j = 0; func_in = 0;
    dst = 0; dst_en = 0; op_ready = 1; wb_valid = 0;
    wb_addr = 0; wb_data = 0;
  endtask

  // Reference model state
  logic [15:0] m_rf [8];
  bit          m_busy [8];
  logic        m_ov, m_ill;
  logic [15:0] m_ri, m_rj;
  logic [2:0]  m_fn;

  function automatic logic [15:0] m_read(logic [2:0] s);
    if (s == 0) return 16'h0;
    if (wb_valid && wb_addr == s) return wb_data;
    return m_rf[s];
  endfunction

  function automatic bit m_waits(logic [2:0] s);
    if (s == 0) return 0;
    if (wb_valid && wb_addr == s) return 0;
    return m_busy[s];
  endfunction

  function automatic bit m_ready();
    return (!m_ov || op_ready) && !m_waits(sel_i) && !m_waits(sel_j);
  endfunction

  task automatic m_reset();
    for (int k = 0; k < 8; k++) begin
      m_rf[k] = 0;
      m_busy[k] = 0;
    end
    m_ov = 0; m_ill = 0; m_ri = 0; m_rj = 0; m_fn = 0;
  endtask

  // Applies one clock edge of the spec's rules to the model
  task automatic m_step();
    bit acc;
    logic [15:0] a, b;
    acc = issue_valid && m_ready();
    a = m_read(sel_i);
    b = m_read(sel_j);
    m_ill = acc && (func_in > 5);
    if (acc && func_in <= 5) begin
      m_ri = a; m_rj = b; m_fn = func_in; m_ov = 1;
    end else if (acc || op_ready) begin
      m_ov = 0;
    end
    if (wb_valid && wb_addr != 0) begin
      m_rf[wb_addr] = wb_data;
      m_busy[wb_addr] = 0;
    end
    if (acc && func_in <= 5 && dst_en && dst != 0)
      m_busy[dst] = 1;
  endtask

  initial begin
    rst = 0;
    idle();

    // Reset held for two cycles
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("rst_op_valid", op_valid, 0);
      chk("rst_ri", ri, 0);
      chk("rst_rj", rj, 0);
      chk("rst_func", func, 0);
      chk("rst_illegal", illegal, 0);
      chk("rst_issue_ready", issue_ready, 1);
    end
    rst = 1;
    @(negedge clk);
    chk("idle_op_valid", op_valid, 0);

    // Directed table
    vq.push_back(mk(0,0,0,0,0,0,1,1,3,16'h12,   1,0,0,0,0,0,1));
    vq.push_back(mk(0,0,0,0,0,0,1,1,5,16'h30,   1,0,0,0,0,0,1));
    vq.push_back(mk(1,3,5,1,6,1,1,0,0,0,        1,1,16'h12,16'h30,1,0,1));
    vq.push_back(mk(1,6,0,1,7,1,1,0,0,0,        0,0,0,0,0,0,0));
    vq.push_back(mk(1,6,0,1,7,1,1,1,6,16'h42,   1,1,16'h42,0,1,0,1));
    vq.push_back(mk(1,3,5,2,0,0,0,0,0,0,        0,1,16'h42,0,1,0,1));
    vq.push_back(mk(1,3,5,2,0,0,0,0,0,0,        0,1,16'h42,0,1,0,1));
    vq.push_back(mk(1,3,5,2,0,0,0,0,0,0,        0,1,16'h42,0,1,0,1));
    vq.push_back(mk(1,3,5,2,0,0,1,0,0,0,        1,1,16'h12,16'h30,2,0,1));
    vq.push_back(mk(1,3,5,6,3,1,1,0,0,0,        1,0,0,0,0,1,0));
    vq.push_back(mk(1,3,0,0,0,0,1,0,0,0,        1,1,16'h12,0,0,0,1));
    vq.push_back(mk(1,0,5,4,0,0,1,1,0,16'hFFFF, 1,1,0,16'h30,4,0,1));
    vq.push_back(mk(0,0,0,0,0,0,1,0,0,0,        1,0,0,0,0,0,0));
    vq.push_back(mk(1,7,0,0,0,0,1,0,0,0,        0,0,0,0,0,0,0));
    vq.push_back(mk(1,3,7,1,7,1,1,1,7,16'h77,   1,1,16'h12,16'h77,1,0,1));
    vq.push_back(mk(1,7,0,0,0,0,1,0,0,0,        0,0,0,0,0,0,0));
    vq.push_back(mk(1,7,7,1,7,1,1,1,7,16'h99,   1,1,16'h99,16'h99,1,0,1));
    vq.push_back(mk(1,0,7,0,0,0,1,0,0,0,        0,0,0,0,0,0,0));
    vq.push_back(mk(1,4,4,3,4,0,1,1,7,16'h1,    1,1,0,0,3,0,1));
    vq.push_back(mk(1,4,7,0,0,0,1,0,0,0,        1,1,0,16'h1,0,0,1));
    vq.push_back(mk(1,3,3,2,3,1,1,0,0,0,        1,1,16'h12,16'h12,2,0,1));
    vq.push_back(mk(1,3,0,0,0,0,1,0,0,0,        0,0,0,0,0,0,0));

    foreach (vq[r]) begin
      drive(vq[r]);
      #1;
      chk($sformatf("v%0d_issue_ready", r), issue_ready, vq[r].eir);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("v%0d_op_valid", r), op_valid, vq[r].eov);
      chk($sformatf("v%0d_illegal", r), illegal, vq[r].eill);
      if (vq[r].cops) begin
        chk($sformatf("v%0d_ri", r), ri, vq[r].eri);
        chk($sformatf("v%0d_rj", r), rj, vq[r].erj);
        chk($sformatf("v%0d_func", r), func, vq[r].ef);
      end
    end

    // Reset in the middle of a stalled handshake
    idle();
    issue_valid = 1; sel_i = 1; sel_j = 1; func_in = 1;
    dst = 2; dst_en = 1; op_ready = 0;
    #1 chk("mid_accept_ready", issue_ready, 1);
    @(posedge clk);
    @(negedge clk);
    chk("mid_op_valid", op_valid, 1);
    issue_valid = 1; sel_i = 2; sel_j = 0; func_in = 0;
    dst = 0; dst_en = 0; op_ready = 0;
    #1 chk("mid_r2_busy", issue_ready, 0);
    #1 rst = 0;
    #1;
    chk("async_op_valid", op_valid, 0);
    chk("async_ri", ri, 0);
    chk("async_ready", issue_ready, 1);
    @(negedge clk);
    rst = 1;
    issue_valid = 1; sel_i = 2; sel_j = 3; func_in = 0;
    op_ready = 1;
    #1 chk("post_rst_ready", issue_ready, 1);
    @(posedge clk);
    @(negedge clk);
    chk("post_rst_op_valid", op_valid, 1);
    chk("post_rst_r2", ri, 0);
    chk("post_rst_r3", rj, 0);

    // Random traffic from a clean reset
    rst = 0;
    idle();
    @(negedge clk);
    rst = 1;
    m_reset();
    for (int c = 0; c < 400; c++) begin
      issue_valid = ($urandom_range(0, 9) < 7);
      sel_i   = 3'($urandom_range(0, 7));
      sel_j   = 3'($urandom_range(0, 7));
      func_in = ($urandom_range(0, 9) == 0) ?
                3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
      dst     = 3'($urandom_range(0, 7));
      dst_en  = ($urandom_range(0, 3) != 0);
      op_ready = ($urandom_range(0, 9) < 7);
      wb_valid = ($urandom_range(0, 1) == 1);
      wb_addr  = 3'($urandom_range(0, 7));
      wb_data  = 16'($urandom);
      #1;
      chk($sformatf("r%0d_issue_ready", c), issue_ready, m_ready());
      m_step();
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("r%0d_op_valid", c), op_valid, m_ov);
      chk($sformatf("r%0d_illegal", c), illegal, m_ill);
      if (m_ov) begin
        chk($sformatf("r%0d_ri", c), ri, m_ri);
        chk($sformatf("r%0d_rj", c), rj, m_rj);
        chk($sformatf("r%0d_func", c), func, m_fn);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/operand_fetch_stage.md
Name: operand_fetch_stage

Overview:
- Register-file and operand-issue stage directly upstream of the team's 3-bit-func ALU.
- Holds REGS general registers of width n and reads two source registers per issued operation.
- Presents the ALU with registered operands ri/rj and func under a valid/ready handshake.
- Accepts ALU results on a write-back port and tracks pending destinations in a busy scoreboard, so no operation issues with a stale operand.

Parameters:
n, 16, data width of registers and ALU operands
REGS, 8, number of registers; R0 is hardwired zero
AW, 3, register address width; REGS must equal 2**AW

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous active-low reset
issue_valid  input  1  upstream operation present
issue_ready  output  1  stage can accept operation this cycle
sel_i  input  AW  source register for ri
sel_j  input  AW  source register for rj
func_in  input  3  ALU function code (000 pass, 001 add, 010 sub, 011 and, 100 or, 101 not-rj)
dst  input  AW  destination register of the operation
dst_en  input  1  operation writes a result
ri  output  n  operand to ALU
rj  output  n  operand to ALU
func  output  3  function code to ALU
op_valid  output  1  ri/rj/func valid
op_ready  input  1  ALU side consumes operand this cycle
wb_valid  input  1  write-back strobe
wb_addr  input  AW  write-back register
wb_data  input  n  write-back value (ALU out)
illegal  output  1  one-cycle pulse: accepted operation had func 110/111

Behaviour:
- Reset (rst=0, asynchronous): all registers 0, busy bits 0, ri=rj=0, func=000, op_valid=0, illegal=0. Reset asserted mid-handshake drops op_valid immediately; the pending operation is lost.
- Register read:
  - R0 always reads 0.
  - Any other register reads regfile[sel].
  - Same-cycle forwarding: if wb_valid and wb_addr==sel and wb_addr!=0, the read returns wb_data.
- Write-back: when wb_valid and wb_addr!=0, regfile[wb_addr]<=wb_data on the edge and busy[wb_addr] clears. Writes to R0 are ignored.
- Source hazard: a source is stalled when busy[sel]=1 and it is not being forwarded this cycle. R0 is never busy.
- Output register free: free = !op_valid || op_ready.
- issue_ready = free && no stalled source. It is combinational from busy, wb_*, sel_*, op_valid and op_ready.
- Accept = issue_valid && issue_ready, with 1-cycle latency:
  - On the next edge, ri/rj latch the read values and func latches func_in.
  - op_valid<=1 if func_in<=101.
  - If dst_en and dst!=0, busy[dst]<=1.
- Illegal func (110/111) on accept:
  - Operation is dropped: op_valid<=0 if free, busy is unchanged.
  - illegal=1 for exactly one cycle.
- Hold: while op_valid && !op_ready, ri/rj/func/op_valid stay stable.
- Drain: if op_ready with no accept, op_valid<=0 on the edge.
- Back-to-back: op_ready and accept in the same cycle replace the operand with no bubble, giving 1 operation/cycle throughput.
- Simultaneous set and clear of the same busy bit (accept with dst==wb_addr while wb_valid): the set wins and the register stays busy. The write-back data is still written.
- Self-dependence: an operation whose source equals its own dst reads the old value, then marks busy.
- Operations with dst_en=0 never touch busy.
- Scoreboard is per-register 1 bit, so only one outstanding write per register. Accepting a second writer to a busy dst is allowed and leaves busy=1 until the next write-back.

Test Plan:
- Reset then idle, with rst released after 2 cycles -> op_valid=0, ri=rj=0, func=000, issue_ready=1, illegal=0.
- Write-back R3=0x0012, R5=0x0030, then issue sel_i=3, sel_j=5, func=001, dst=6, dst_en=1 with op_ready=1 -> next cycle ri=0x0012, rj=0x0030, func=001, op_valid=1, busy[6]=1.
- Issue a read of R6 while busy[6]=1 -> issue_ready=0 until wb_valid, wb_addr=6, wb_data=0x0042. In that wb cycle issue_ready=1, the operation is accepted, and next cycle ri=0x0042 (forwarded).
- op_ready=0 for 3 cycles after an accept -> ri/rj/func unchanged and issue_ready=0. Raise op_ready with a new issue pending -> operand replaced the same edge, no bubble.
- Issue func=110 -> illegal pulses 1 cycle, op_valid stays 0, busy unchanged. Issue sel_i=0 with wb to R0 of 0xFFFF -> ri=0.
- Assert rst low while op_valid=1 and busy[2]=1 -> op_valid=0 and busy cleared asynchronously. After release, a read of R2 returns 0 and issue_ready=1.
